// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: sequencer for a glitch-free two-source clock multiplexer.
// Accepts switch requests, checks target presence, drives the mux select,
// waits a settle window before reporting done, then enforces a dwell time.
// Optional feature: define CLK_SWITCH_AUTO_FAILOVER_EN to switch away from a
// lost source automatically when the other source is present.
module clk_switch_ctrl #(
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned HOLD_CYC   = 16,
    parameter int unsigned CW         = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_src,
    output logic req_ready,
    input  logic ok0,
    input  logic ok1,
    output logic sel,
    output logic cur_src,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StHold
    } state_e;

    localparam logic [CW-1:0] SettleLoad = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] HoldLoad   = CW'(HOLD_CYC - 1);

    state_e        state_q, state_d;
    logic          sel_q, sel_d;
    logic          cur_q, cur_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic req_ok;   // presence of the requested source
    logic tgt_ok;   // presence of the source being switched to

    assign req_ok = req_src ? ok1 : ok0;
    assign tgt_ok = sel_q ? ok1 : ok0;

`ifdef CLK_SWITCH_AUTO_FAILOVER_EN
    logic cur_ok;
    logic alt_ok;
    assign cur_ok = cur_q ? ok1 : ok0;
    assign alt_ok = cur_q ? ok0 : ok1;
`endif

    // Next-state, select, counter and pulse logic.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_src == cur_q) begin
                        done_d = 1'b1;
                    end else if (!req_ok) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d   = req_src;
                        cnt_d   = SettleLoad;
                        state_d = StSettle;
                    end
`ifdef CLK_SWITCH_AUTO_FAILOVER_EN
                end else if (!cur_ok && alt_ok) begin
                    // Current source lost and the other one is alive: fail over.
                    sel_d   = ~cur_q;
                    cnt_d   = SettleLoad;
                    state_d = StSettle;
`endif
                end
            end
            StSettle: begin
                if (!tgt_ok) begin
                    // Target vanished mid-switch: fall back to the confirmed source.
                    sel_d   = cur_q;
                    err_d   = 1'b1;
                    cnt_d   = HoldLoad;
                    state_d = StHold;
                end else if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    cur_d   = sel_q;
                    cnt_d   = HoldLoad;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= 1'b0;
            cur_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == StIdle) && !rst;
    assign busy      = (state_q != StIdle);
    assign sel       = sel_q;
    assign cur_src   = cur_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed self-checking bench for clk_switch_ctrl with default parameters.
module tb_clk_switch_ctrl;

    logic clk;
    logic rst;
    logic req_valid;
    logic req_src;
    logic req_ready;
    logic ok0;
    logic ok1;
    logic sel;
    logic cur_src;
    logic busy;
    logic done;
    logic err;

    int errors = 0;
    int checks = 0;

    clk_switch_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_src  (req_src),
        .req_ready(req_ready),
        .ok0      (ok0),
        .ok1      (ok1),
        .sel      (sel),
        .cur_src  (cur_src),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_src   = 1'b0;
        ok0       = 1'b1;
        ok1       = 1'b1;
        tick();
        tick();
        check("ready_in_rst", req_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_sel", sel, 1'b0);
        check("rst_cur", cur_src, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", req_ready, 1'b1);

        // Full switch to clk1.
        req_valid = 1'b1;
        req_src   = 1'b1;
        tick();                              // E0
        req_valid = 1'b0;
        check("sw_sel", sel, 1'b1);
        check("sw_busy", busy, 1'b1);
        check("sw_ready", req_ready, 1'b0);
        check("sw_cur_old", cur_src, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick();                          // E0+1 .. E0+7
            check("sw_no_done", done, 1'b0);
        end
        tick();                              // E0+8
        check("sw_done", done, 1'b1);
        check("sw_err", err, 1'b0);
        check("sw_cur_new", cur_src, 1'b1);
        tick();                              // E0+9
        check("sw_done_pulse", done, 1'b0);
        for (int i = 0; i < 14; i++) tick(); // E0+23
        check("sw_hold_ready", req_ready, 1'b0);
        tick();                              // E0+24
        check("sw_ready_back", req_ready, 1'b1);
        check("sw_busy_end", busy, 1'b0);

        // Same-source request while on clk1.
        req_valid = 1'b1;
        req_src   = 1'b1;
        tick();
        req_valid = 1'b0;
        check("same1_done", done, 1'b1);
        check("same1_sel", sel, 1'b1);
        check("same1_busy", busy, 1'b0);

        // Back to reset values, then same-source request for clk0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst2_sel", sel, 1'b0);
        check("rst2_cur", cur_src, 1'b0);
        req_valid = 1'b1;
        req_src   = 1'b0;
        tick();
        req_valid = 1'b0;
        check("same0_done", done, 1'b1);
        check("same0_sel", sel, 1'b0);
        check("same0_busy", busy, 1'b0);
        check("same0_ready", req_ready, 1'b1);
        tick();
        check("same0_pulse", done, 1'b0);

        // Rejected request: target absent.
        ok1       = 1'b0;
        req_valid = 1'b1;
        req_src   = 1'b1;
        tick();
        req_valid = 1'b0;
        check("rej_err", err, 1'b1);
        check("rej_done", done, 1'b0);
        check("rej_sel", sel, 1'b0);
        check("rej_ready", req_ready, 1'b1);
        tick();
        check("rej_pulse", err, 1'b0);

        // Abort during SETTLE: ok1 drops, sampled at E0+3.
        ok1       = 1'b1;
        req_valid = 1'b1;
        req_src   = 1'b1;
        tick();                              // E0
        req_valid = 1'b0;
        check("ab_sel", sel, 1'b1);
        tick();
        tick();                              // E0+2
        ok1 = 1'b0;
        tick();                              // E0+3
        check("ab_revert", sel, 1'b0);
        check("ab_err", err, 1'b1);
        check("ab_done", done, 1'b0);
        check("ab_busy", busy, 1'b1);
        ok1 = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();                          // E0+4 .. E0+18
            check("ab_no_done", done, 1'b0);
        end
        check("ab_hold_ready", req_ready, 1'b0);
        tick();                              // E0+19
        check("ab_ready_back", req_ready, 1'b1);
        check("ab_cur", cur_src, 1'b0);

        // Reset mid-SETTLE.
        req_valid = 1'b1;
        req_src   = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("rs_sel_pre", sel, 1'b1);
        rst = 1'b1;
        tick();
        check("rs_sel", sel, 1'b0);
        check("rs_busy", busy, 1'b0);
        check("rs_ready_in_rst", req_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("rs_ready", req_ready, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rs_no_done", done, 1'b0);
        end

        // Move to clk1, then lose clk1.
        req_valid = 1'b1;
        req_src   = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 24; i++) tick();
        check("fo_pre_cur", cur_src, 1'b1);
        check("fo_pre_ready", req_ready, 1'b1);
        ok1 = 1'b0;
        tick();                              // F
`ifdef CLK_SWITCH_AUTO_FAILOVER_EN
        check("fo_sel", sel, 1'b0);
        check("fo_busy", busy, 1'b1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("fo_no_done", done, 1'b0);
        end
        tick();                              // F+8
        check("fo_done", done, 1'b1);
        check("fo_cur", cur_src, 1'b0);
`else
        check("nofo_sel", sel, 1'b1);
        check("nofo_busy", busy, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("nofo_no_done", done, 1'b0);
        end
        check("nofo_sel_end", sel, 1'b1);
        check("nofo_cur", cur_src, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_switch_ctrl.md
# clk_switch_ctrl

Sequencer for the glitch-free two-source clock multiplexer. It accepts switch requests over a valid/ready handshake, checks that the target clock is present, and drives the multiplexer's `sel` input. It then enforces a settle window before reporting completion, followed by a minimum dwell time before the next switch. It runs on an always-on control clock, and all of its inputs are synchronous to that clock.

## Interface
- `SETTLE_CYC`, default 8: cycles from the `sel` change to the `done` pulse; must be ≥1.
- `HOLD_CYC`, default 16: minimum dwell, in cycles, after `done` before the next request is accepted; must be ≥1.
- `CW`, default 5: counter width; must satisfy 2^CW > max(SETTLE_CYC, HOLD_CYC).

- `clk` in 1: control clock, always running. One clock domain.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: switch request.
- `req_src` in 1: requested source (0 = clk0, 1 = clk1).
- `req_ready` out 1: equals (state==IDLE) && !rst.
- `ok0`, `ok1` in 1: presence flags for clk0 and clk1, already synchronized to `clk`.
- `sel` out 1: registered; drives the mux `sel`.
- `cur_src` out 1: last confirmed source, registered.
- `busy` out 1: high when state != IDLE.
- `done` out 1: one-cycle pulse; the switch completed.
- `err` out 1: one-cycle pulse; request rejected or aborted.

## Operation
- Reset values: state=IDLE, `sel`=0, `cur_src`=0, `done`=0, `err`=0, `busy`=0, counter=0.
- States are IDLE, SETTLE and HOLD.
- In IDLE, a request is accepted when `req_valid`&&`req_ready`:
  - If `req_src`==`cur_src`: pulse `done` on the next cycle; `sel` does not change; remain in IDLE with no HOLD.
  - Else if the target flag (ok0/ok1) is 0: pulse `err` on the next cycle; remain in IDLE.
  - Else: `sel`<=`req_src`, counter<=SETTLE_CYC-1, go to SETTLE.
- In SETTLE:
  - If the target flag drops: `sel`<=`cur_src` (revert), pulse `err`, counter<=HOLD_CYC-1, go to HOLD.
  - Else if counter==0: pulse `done`, `cur_src`<=`sel`, counter<=HOLD_CYC-1, go to HOLD.
  - Otherwise decrement the counter.
- In HOLD: at counter==0 go to IDLE; otherwise decrement. Requests are ignored, because `req_ready`=0.
- `done` and `err` are never high in the same cycle.
- `rst` asserted in any state restores the reset values at the next edge, including `sel`=0. The downstream mux's own glitch-free logic handles that transition.

## Timing
- Let edge E0 be the edge at which a request is accepted.
- `sel` is new after E0.
- `done` is high in the cycle following edge E0+SETTLE_CYC. `req_ready` returns to 1 after edge E0+SETTLE_CYC+HOLD_CYC.
- With the defaults, `done` is high in cycle 8 after acceptance and `req_ready`=1 again from cycle 24.
- A same-source request or a rejected request gives `done`/`err` in the cycle right after E0, and `req_ready` stays 1 the whole time.
- A SETTLE abort caused by the target flag dropping at edge Ek gives `err` after Ek, with `sel` reverted in the same cycle. IDLE is reached HOLD_CYC cycles later.
- There is no combinational path from any input to `sel`, `done` or `err`.

## Configuration
- Macro: `CLK_SWITCH_AUTO_FAILOVER_EN`.
- When defined: in IDLE with `req_valid`=0, if the flag for `cur_src` is 0 and the other flag is 1, the controller starts a switch to the other source itself. It uses the same SETTLE/HOLD sequence and ends with a `done` pulse.
  - An external `req_valid` in the same cycle takes priority over failover.
  - If both flags are 0, no action is taken.
- When undefined: loss of the current source is ignored, and the controller changes `sel` only on external requests.

## Test plan
- Reset, then request `req_src`=1 with `ok1`=1: `sel`=1 after E0, `done` pulses at E0+8, `cur_src`=1, and `req_ready` is 0 until E0+24.
- Request `req_src`=0 while `cur_src`=0: `done` pulses in the next cycle, `sel` stays 0 and `busy` stays 0.
- Request `req_src`=1 with `ok1`=0: `err` pulses in the next cycle, `sel` stays 0 and `req_ready` stays 1.
- Drop `ok1` at E0+3 during SETTLE: `sel` reverts to 0, `err` pulses, `done` never fires, and IDLE is reached 16 cycles later.
- Assert `rst` mid-SETTLE: at the next edge `sel`=0, state=IDLE, `busy`=0, and no `done` pulse occurs.
- With `CLK_SWITCH_AUTO_FAILOVER_EN` defined, `cur_src`=1, `ok1` falling to 0 and `ok0`=1: `sel`=0 after the next edge and `done` pulses 8 cycles later. With the macro undefined, `sel` stays 1.
